psa_accum: RTL

- Streaming packed-saturating accumulator sitting directly downstream of the 16-bit parallel sub-word adder datapath.
- Consumes a stream of packed 16-bit operands, each holding four signed 4-bit lanes.
- Accumulates LEN operands per lane with the same saturate-on-overflow rule as the parallel adder, then presents one packed result plus an error flag.
- Valid/ready handshakes on both sides; used for multi-operand PADDSB sequences and reduction tests.

---
 rtl/psa_pkg.sv | 33 +++
 rtl/psa_sat_lane4.sv | 33 +++
 rtl/psa_accum.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/psa_pkg.sv
// -----------------------------------------------------------------------------
// psa_pkg
//   Shared definitions for the packed-saturating accumulator slice.
//
//   Contents:
//     LANES / LANE_W     : four signed 4-bit lanes packed into 16 bits
//     DATA_W             : packed operand width
//     SAT_POS / SAT_NEG  : lane saturation values (+7 / -8)
//     state_e            : accumulator FSM states, 2-bit encoding
//     sat_value()        : saturation value selected by the operand sign
// -----------------------------------------------------------------------------
package psa_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int DATA_W = LANES * LANE_W;

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // An overflow always moves toward the sign of the (shared) operand sign,
  // so the clamp value depends only on that sign bit.
  function automatic logic [LANE_W-1:0] sat_value(input logic sign_bit);
    return sign_bit ? SAT_NEG : SAT_POS;
  endfunction

endpackage : psa_pkg

// File: rtl/psa_sat_lane4.sv
// -----------------------------------------------------------------------------
// psa_sat_lane4
//   Combinational signed 4-bit saturating adder for one lane.
//
//   Ports:
//     a    [3:0] in  : accumulator lane (signed)
//     b    [3:0] in  : operand lane (signed)
//     sum  [3:0] out : a + b, clamped to +7 / -8 on overflow
//     ovfl       out : high when a + b left the signed 4-bit range
//
//   A lane already sitting at +7 or -8 stays there for further same-sign
//   adds because every such add overflows again and re-clamps.
// -----------------------------------------------------------------------------
module psa_sat_lane4
  import psa_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum,
  output logic              ovfl
);

  logic [LANE_W-1:0] raw_sum;

  always_comb begin
    // Modulo-16 add; the carry out is irrelevant for signed overflow.
    raw_sum = a + b;
    // Signed overflow: both operands share a sign and the result does not.
    ovfl    = (a[LANE_W-1] == b[LANE_W-1]) && (raw_sum[LANE_W-1] != a[LANE_W-1]);
    sum     = ovfl ? sat_value(a[LANE_W-1]) : raw_sum;
  end

endmodule : psa_sat_lane4

// File: rtl/psa_accum.sv
// -----------------------------------------------------------------------------
// psa_accum
//   Streaming packed-saturating accumulator. Accepts LEN packed operands of
//   four signed 4-bit lanes, accumulates each lane with saturate-on-overflow,
//   then presents one packed result and a sticky overflow flag.
//
//   Parameters:
//     LEN            : operands per accumulation, 2..15
//
//   Ports:
//     clk            in   rising-edge clock
//     rst_n          in   asynchronous active-low reset
//     in_valid       in   in_data valid
//     in_ready       out  block accepts in_data (high in IDLE and ACC)
//     in_data  [15:0] in  packed operand, lane k = in_data[4k+3:4k]
//     out_valid      out  finished result held on out_sum / out_err
//     out_ready      in   consumer takes the result
//     out_sum  [15:0] out packed saturated accumulation (registered)
//     out_err        out  sticky OR of all lane overflows (registered)
//     busy           out  state is ACC or DONE
//     out_lane_err [3:0] out  per-lane sticky overflow flags, only when
//                             PSA_ACCUM_LANE_ERR_EN is defined
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high on that side. in_ready and out_valid are pure decodes of the
//   state register, so they never depend on in_valid or out_ready and are
//   never high together. Once out_valid is high, the result and the flags
//   stay stable until out_ready is seen.
//
//   Build option: PSA_ACCUM_LANE_ERR_EN adds the out_lane_err port.
// -----------------------------------------------------------------------------
module psa_accum
  import psa_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_err,
  output logic              busy
`ifdef PSA_ACCUM_LANE_ERR_EN
  ,
  output logic [LANES-1:0]  out_lane_err
`endif
);

  // Count value held just before the LEN-th accept.
  localparam logic [3:0] CNT_LAST = 4'(LEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,  state_d;
  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [3:0]        cnt_q,    cnt_d;
  logic              err_q,    err_d;
`ifdef PSA_ACCUM_LANE_ERR_EN
  logic [LANES-1:0]  lane_err_q, lane_err_d;
`endif

  logic [DATA_W-1:0] lane_sum;
  logic [LANES-1:0]  lane_ovfl;
  logic              accept;

  // ---------------------------------------------------------------------------
  // Lane adders. The accumulator is zero in IDLE, so the first beat goes
  // through the same adders as later beats and simply lands unchanged.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    psa_sat_lane4 u_lane (
      .a    (acc_q   [k*LANE_W +: LANE_W]),
      .b    (in_data [k*LANE_W +: LANE_W]),
      .sum  (lane_sum[k*LANE_W +: LANE_W]),
      .ovfl (lane_ovfl[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
`ifdef PSA_ACCUM_LANE_ERR_EN
    lane_err_d = lane_err_q;
`endif
    accept     = in_valid && in_ready;

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d      = lane_sum;
          cnt_d      = cnt_q + 4'd1;
          err_d      = err_q | (|lane_ovfl);
`ifdef PSA_ACCUM_LANE_ERR_EN
          lane_err_d = lane_err_q | lane_ovfl;
`endif
          // cnt is 0 in IDLE and LEN >= 2, so IDLE can only move to ACC.
          state_d    = (cnt_q == CNT_LAST) ? DONE : ACC;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d    = IDLE;
          acc_d      = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
`ifdef PSA_ACCUM_LANE_ERR_EN
          lane_err_d = '0;
`endif
        end
      end

      default: begin
        state_d    = IDLE;
        acc_d      = '0;
        cnt_d      = '0;
        err_d      = 1'b0;
`ifdef PSA_ACCUM_LANE_ERR_EN
        lane_err_d = '0;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
`ifdef PSA_ACCUM_LANE_ERR_EN
      lane_err_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`ifdef PSA_ACCUM_LANE_ERR_EN
      lane_err_q <= lane_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight decodes of flops only.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_err   = err_q;
`ifdef PSA_ACCUM_LANE_ERR_EN
  assign out_lane_err = lane_err_q;
`endif

endmodule : psa_accum
